// File: rtl/serial_link_partner.sv
// External-clock serial link responder: samples SO on SCK rise, drives SI MSB first,
// and buffers received bytes in a small RX FIFO with a mid-byte SCK timeout.
module serial_link_partner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck_in,
  input  logic       so_in,
  output logic       si_out,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       rx_overflow,
  output logic       byte_done,
  output logic       timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sck_sync, so_sync;
  logic                   sck_prev;
  logic                   sck_s, so_s, rise, fall;

  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift, tx_shift, tx_cur, tx_hold;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [7:0]    rx_byte, head_n;
  logic          byte_end, abort, full, empty, pop_ok, push_ok, drop;

  // Sync chains idle high so a low SCK after reset only produces a harmless fall at bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '1;
      so_sync  <= '1;
      sck_prev <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      so_sync  <= {so_sync[SYNC_STAGES-2:0], so_in};
      sck_prev <= sck_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign so_s   = so_sync[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev;
  assign fall   = ~sck_s & sck_prev;
  assign si_out = tx_shift[7];

  always_comb begin
    rx_byte  = {rx_shift[6:0], so_s};
    byte_end = rise && (bit_cnt == 3'd7);
    abort    = !rise && !fall && (bit_cnt != 3'd0) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    full     = (count == CW'(FIFO_DEPTH));
    empty    = (count == '0);
    pop_ok   = rx_pop && !empty;
    push_ok  = byte_end && (!full || pop_ok);
    drop     = byte_end && full && !pop_ok;
    wr_ptr_n = push_ok ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count + CW'(push_ok) - CW'(pop_ok);
    // The byte being pushed becomes the head when it lands in an otherwise drained FIFO
    if (count_n == '0)
      head_n = 8'h00;
    else if (push_ok && (wr_ptr == rd_ptr_n))
      head_n = rx_byte;
    else
      head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'hFF;
      tx_cur      <= 8'hFF;
      tx_hold     <= 8'hFF;
      tx_ready    <= 1'b1;
      tmo_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
      byte_done   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      byte_done   <= byte_end;
      timeout     <= abort;
      rx_overflow <= rx_overflow | drop;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      rx_data     <= head_n;
      rx_valid    <= (count_n != '0);

      if (rise || fall || (bit_cnt == 3'd0) || abort)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);

      if (rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_end) begin
          if (!tx_ready) begin
            tx_shift <= tx_hold;
            tx_cur   <= tx_hold;
            tx_ready <= 1'b1;
          end else begin
            tx_shift <= tx_cur;
          end
        end
      end else if (fall && (bit_cnt != 3'd0)) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end else if (abort) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        tx_shift <= tx_cur;
      end

      // A load coinciding with byte completion is held for the byte after the reload
      if (tx_load) begin
        if (byte_end) begin
          tx_hold  <= tx_data;
          tx_ready <= 1'b0;
        end else if (tx_ready) begin
          if (bit_cnt == 3'd0) begin
            tx_shift <= tx_data;
            tx_cur   <= tx_data;
          end else begin
            tx_hold  <= tx_data;
            tx_ready <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_link_partner.sv
// Directed bench for serial_link_partner: a behavioural SCK master plus vector table
// and hand-written sequences for mid-byte load, overflow, timeout and reset.
module tb_serial_link_partner;

  localparam int TMO     = 200;
  localparam int HALF    = 6;
  localparam int NO_LOAD = 99;

  logic       clk = 1'b0;
  logic       reset, sck_in, so_in, si_out;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_pop, rx_overflow, byte_done, timeout;

  int nchecks = 0;
  int nfails  = 0;
  int bd_cnt  = 0;
  int to_cnt  = 0;

  typedef struct {
    logic       preload;
    logic [7:0] load_val;
    logic [7:0] mo;
    logic [7:0] exp_si;
  } vec_t;

  vec_t vecs[4];

  serial_link_partner #(
    .SYNC_STAGES(2),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sck_in(sck_in),
    .so_in(so_in),
    .si_out(si_out),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_pop(rx_pop),
    .rx_overflow(rx_overflow),
    .byte_done(byte_done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Count every cycle a pulse output is high so stretched pulses show up as extra counts
  always @(negedge clk) begin
    if (byte_done === 1'b1) bd_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  // Master clocks nbits of mo MSB first, sampling si_out just before each rising edge
  task automatic apply_stimulus(input logic [7:0] mo, input int nbits, input int load_bit,
                                input logic [7:0] load_val, output logic [7:0] mi,
                                output logic rdy_last);
    mi = 8'h00;
    rdy_last = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      so_in = mo[7-b];
      wait_cycles(HALF);
      mi[7-b] = si_out;
      if (b == nbits - 1) rdy_last = tx_ready;
      sck_in = 1'b1;
      wait_cycles(HALF);
      if (b == load_bit) begin
        tx_data = load_val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
      end
      sck_in = 1'b0;
    end
    wait_cycles(HALF);
  endtask

  initial begin
    logic [7:0] mi;
    logic       rdy;
    int         bd0, to0;

    vecs[0] = '{preload: 1'b0, load_val: 8'h00, mo: 8'hA5, exp_si: 8'hFF};
    vecs[1] = '{preload: 1'b1, load_val: 8'h3C, mo: 8'h00, exp_si: 8'h3C};
    vecs[2] = '{preload: 1'b0, load_val: 8'h00, mo: 8'hFF, exp_si: 8'h3C};
    vecs[3] = '{preload: 1'b1, load_val: 8'hC3, mo: 8'h5A, exp_si: 8'hC3};

    reset   = 1'b1;
    sck_in  = 1'b0;
    so_in   = 1'b0;
    tx_data = 8'h00;
    tx_load = 1'b0;
    rx_pop  = 1'b0;
    wait_cycles(3);
    check_output("reset si_out", 32'(si_out), 32'd1);
    check_output("reset tx_ready", 32'(tx_ready), 32'd1);
    check_output("reset rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset rx_data", 32'(rx_data), 32'h00);
    check_output("reset rx_overflow", 32'(rx_overflow), 32'd0);
    check_output("reset byte_done", 32'(byte_done), 32'd0);
    check_output("reset timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    wait_cycles(4);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].preload) idle_load(vecs[i].load_val);
      bd0 = bd_cnt;
      apply_stimulus(vecs[i].mo, 8, NO_LOAD, 8'h00, mi, rdy);
      check_output($sformatf("vec%0d si", i), 32'(mi), 32'(vecs[i].exp_si));
      check_output($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'd1);
      check_output($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].mo));
      check_output($sformatf("vec%0d byte_done", i), 32'(bd_cnt - bd0), 32'd1);
      pop_one();
      check_output($sformatf("vec%0d empty", i), 32'(rx_valid), 32'd0);
    end

    // Mid-byte load goes to the holding register and is sent on the following byte
    idle_load(8'h3C);
    check_output("idle load tx_ready", 32'(tx_ready), 32'd1);
    apply_stimulus(8'h11, 8, 2, 8'h81, mi, rdy);
    check_output("midload si", 32'(mi), 32'h3C);
    check_output("midload tx_ready before 8th rise", 32'(rdy), 32'd0);
    check_output("midload tx_ready after byte", 32'(tx_ready), 32'd1);
    check_output("midload rx_data", 32'(rx_data), 32'h11);
    pop_one();
    apply_stimulus(8'h22, 8, NO_LOAD, 8'h00, mi, rdy);
    check_output("held byte si", 32'(mi), 32'h81);
    pop_one();
    apply_stimulus(8'h33, 8, NO_LOAD, 8'h00, mi, rdy);
    check_output("repeat byte si", 32'(mi), 32'h81);
    pop_one();
    check_output("drained", 32'(rx_valid), 32'd0);

    // Nine bytes into an eight-entry FIFO: the ninth is dropped
    for (int v = 1; v <= 9; v++) begin
      apply_stimulus(8'(v), 8, NO_LOAD, 8'h00, mi, rdy);
      if (v == 8) check_output("full no overflow", 32'(rx_overflow), 32'd0);
    end
    check_output("overflow set", 32'(rx_overflow), 32'd1);
    for (int v = 1; v <= 8; v++) begin
      check_output($sformatf("fifo order %0d", v), 32'(rx_data), 32'(v));
      pop_one();
    end
    check_output("after drain rx_valid", 32'(rx_valid), 32'd0);
    check_output("after drain rx_data", 32'(rx_data), 32'h00);
    check_output("overflow sticky", 32'(rx_overflow), 32'd1);

    // Three bits then silence: framing aborts once, nothing is pushed
    bd0 = bd_cnt;
    to0 = to_cnt;
    apply_stimulus(8'hE0, 3, NO_LOAD, 8'h00, mi, rdy);
    check_output("partial si bit4", 32'(si_out), 32'd0);
    wait_cycles(150);
    check_output("no early timeout", 32'(to_cnt - to0), 32'd0);
    for (int c = 0; c < 100 && to_cnt == to0; c++) @(negedge clk);
    wait_cycles(3);
    check_output("timeout pulse", 32'(to_cnt - to0), 32'd1);
    check_output("timeout no push", 32'(rx_valid), 32'd0);
    check_output("timeout no byte_done", 32'(bd_cnt - bd0), 32'd0);
    check_output("timeout si restart", 32'(si_out), 32'd1);
    apply_stimulus(8'h5A, 8, NO_LOAD, 8'h00, mi, rdy);
    check_output("post-timeout si", 32'(mi), 32'h81);
    check_output("post-timeout rx_data", 32'(rx_data), 32'h5A);
    pop_one();

    // Reset mid-byte with two bytes queued
    apply_stimulus(8'hAA, 8, NO_LOAD, 8'h00, mi, rdy);
    apply_stimulus(8'hBB, 8, NO_LOAD, 8'h00, mi, rdy);
    apply_stimulus(8'hCC, 5, NO_LOAD, 8'h00, mi, rdy);
    check_output("pre-reset rx_data", 32'(rx_data), 32'hAA);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(2);
    check_output("mid reset si_out", 32'(si_out), 32'd1);
    check_output("mid reset rx_valid", 32'(rx_valid), 32'd0);
    check_output("mid reset rx_data", 32'(rx_data), 32'h00);
    check_output("mid reset rx_overflow", 32'(rx_overflow), 32'd0);
    check_output("mid reset tx_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    wait_cycles(4);
    apply_stimulus(8'h77, 8, NO_LOAD, 8'h00, mi, rdy);
    check_output("post-reset si", 32'(mi), 32'hFF);
    check_output("post-reset rx_data", 32'(rx_data), 32'h77);
    pop_one();
    check_output("post-reset single byte", 32'(rx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/serial_link_partner.md
Name: serial_link_partner

Overview:
- External-clock responder for the Game Boy serial link: the far end of the cable from the Serial block, which acts as the clock master.
- Samples the master's SO line on SCK rising edges and drives SI back, MSB first, with its own transmit byte.
- Received bytes are buffered in an RX FIFO for a testbench or host model, for example to capture serial-console test output.
- A mid-byte SCK timeout resynchronises framing if the master stops clocking.

Parameters:
SYNC_STAGES, 2, flops in the synchroniser on sck_in and so_in (minimum 2)
FIFO_DEPTH, 8, RX FIFO entries (power of 2, minimum 2)
TIMEOUT_CYCLES, 4096, clk cycles with no SCK edge mid-byte before framing aborts

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sck_in  input  1  serial clock from master (asynchronous to clk)
so_in  input  1  master data out (asynchronous)
si_out  output  1  data to master
tx_data  input  8  next byte to send
tx_load  input  1  strobe: accept tx_data when tx_ready=1
tx_ready  output  1  tx holding register empty
rx_data  output  8  FIFO head byte; 8'h00 when empty
rx_valid  output  1  FIFO not empty
rx_pop  input  1  pop head; ignored when empty
rx_overflow  output  1  sticky: a byte was dropped because the FIFO was full
byte_done  output  1  1-cycle pulse when a byte completes
timeout  output  1  1-cycle pulse when framing aborts

Behaviour:
- Clock and reset: single clk domain. Reset is synchronous and active-high; it is sampled only on the clk rising edge.
- Synchroniser: sck_in and so_in pass through identical SYNC_STAGES flop chains.
  - rise = sck_s & ~sck_prev; fall = ~sck_s & sck_prev.
  - so_s is therefore aligned with sck_s.
- Reset values:
  - tx_shift = tx_cur = 8'hFF; si_out = 1.
  - bit_cnt = 0; rx_shift = 0.
  - FIFO empty; rx_valid = 0; rx_data = 0.
  - tx_ready = 1; rx_overflow = 0; byte_done = 0; timeout = 0; timeout counter = 0.
  - Reset mid-byte discards the partial byte and FIFO contents.
- si_out = tx_shift[7] at all times (registered).
- On rise:
  - rx_shift <= {rx_shift[6:0], so_s}; bit_cnt++.
  - When bit_cnt was 7:
    - bit_cnt <= 0; byte_done pulses the next cycle.
    - Byte {rx_shift[6:0], so_s} is pushed to the FIFO.
    - If tx_ready=0: tx_shift <= tx_hold, tx_cur <= tx_hold, tx_ready <= 1. Otherwise tx_shift <= tx_cur, so the last byte repeats.
- On fall with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 1'b1}. A fall with bit_cnt == 0 does nothing.
- tx_load:
  - bit_cnt == 0 and tx_ready = 1: tx_data loads tx_shift and tx_cur directly; tx_ready stays 1.
  - bit_cnt != 0 and tx_ready = 1: tx_data goes to tx_hold; tx_ready <= 0.
  - tx_ready = 0: ignored.
  - tx_load in the same cycle as a byte-completing rise: the completion reload happens first, then tx_data is captured into tx_hold (tx_ready <= 0).
- FIFO:
  - Push when full drops the byte and sets rx_overflow; the flag stays set until reset.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Push and pop in the same cycle when empty: the push lands and the pop is ignored.
  - rx_data/rx_valid reflect head state registered at the cycle end; new data appears one cycle after the push.
- Timeout:
  - The counter clears on any rise or fall, and whenever bit_cnt == 0.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES: bit_cnt <= 0, rx_shift <= 0, tx_shift <= tx_cur (restart the same byte), no FIFO push, and timeout pulses for 1 cycle.
- Edge latency: an edge on sck_in is acted on SYNC_STAGES+1 clk cycles later. The master's half-period must be at least SYNC_STAGES+2 clk cycles.

Test Plan:
- After reset with no tx_load, the master clocks 8 bits of 8'hA5 -> si_out sequence 1,1,1,1,1,1,1,1. FIFO receives 8'hA5; rx_valid=1; byte_done pulses once.
- tx_load 8'h3C while idle, then the master clocks 8'h00 -> master samples 0,0,1,1,1,1,0,0. rx_data=8'h00.
- tx_load 8'h81 mid-byte while sending 8'h3C -> tx_ready=0 until the 8th rise. The next byte sends 8'h81; the following byte (no new load) repeats 8'h81.
- Clock 9 bytes (8'h01..8'h09) with no pops, FIFO_DEPTH=8 -> 8'h09 dropped; rx_overflow=1. Popping yields 01..08 in order, then rx_valid=0 and rx_data=8'h00.
- Clock 3 bits, then idle for TIMEOUT_CYCLES -> timeout pulse and no push. A fresh 8-bit 8'h5A is received correctly, and si_out restarts from tx_cur bit7.
- Assert reset after 5 bits with the FIFO holding 2 bytes -> all outputs return to reset values; si_out=1; the next full byte is received intact.
